pair_op_sequencer: RTL and testbench

//  FSM controller that sequences the memA/memB datapath (two operand registers, comparator,

---
 rtl/pair_op_sequencer.sv | 125 ++++++++++++
 tb/tb_pair_op_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pair_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pair_op_sequencer
// Purpose  : Control FSM for the memA/memB pair datapath. For every result
//            index j it reads A[2j] and A[2j+1] into r1/r2, latches the
//            comparator sign into the add/sub mux select, then writes B[j].
//            Brackets the whole pass with a busy level and a done pulse.
// Revision : 1.0  initial release
// ============================================================================
module pair_op_sequencer #(
  parameter int B_DEPTH = 4,
  parameter int AW_A    = 3,
  parameter int AW_B    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            sign,
  output logic [AW_A-1:0] addr_a,
  output logic            we_a,
  output logic [AW_B-1:0] addr_b,
  output logic            we_b,
  output logic            ld_r1,
  output logic            ld_r2,
  output logic            sel,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    CMP  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [AW_B-1:0] J_LAST = AW_B'(B_DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW_B-1:0] j_q, j_d;
  logic            sel_q, sel_d;

  // State, pair index and latched mux select registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          j_d     = '0;
          state_d = RD0;
        end
      end
      RD0:  state_d = RD1;
      RD1:  state_d = CMP;
      CMP: begin
        // r1/r2 are both valid here, so the comparator result is final
        sel_d   = sign;
        state_d = WR;
      end
      WR: begin
        if (j_q == J_LAST) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = RD0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Moore output decode; the write strobe is additionally withheld in a
  // cycle where reset or abort is asserted so a cancelled WR never lands
  always_comb begin
    addr_a = '0;
    addr_b = '0;
    we_a   = 1'b0;
    we_b   = 1'b0;
    ld_r1  = 1'b0;
    ld_r2  = 1'b0;
    sel    = sel_q;
    busy   = (state_q != IDLE);
    done   = 1'b0;
    case (state_q)
      RD0: begin
        addr_a = {j_q, 1'b0};
        ld_r1  = 1'b1;
      end
      RD1: begin
        addr_a = {j_q, 1'b1};
        ld_r2  = 1'b1;
      end
      WR: begin
        addr_b = j_q;
        we_b   = reset & ~abort;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pair_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pair_op_sequencer
// Purpose  : Directed bench for pair_op_sequencer with a behavioural model of
//            the memA/memB datapath (operand regs, comparator, add/sub mux).
// Revision : 1.0  initial release
// ============================================================================
module tb_pair_op_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, sign;
  logic [2:0] addr_a;
  logic [1:0] addr_b;
  logic       we_a, we_b, ld_r1, ld_r2, sel, busy, done;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [4];
  logic [7:0] r1_m, r2_m;
  logic       fill_b;
  logic [7:0] fill_val;
  int         wb_cnt = 0;
  int         done_cnt = 0;
  logic [1:0] wlog [64];

  pair_op_sequencer #(.B_DEPTH(4), .AW_A(3), .AW_B(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .sign(sign),
    .addr_a(addr_a), .we_a(we_a), .addr_b(addr_b), .we_b(we_b),
    .ld_r1(ld_r1), .ld_r2(ld_r2), .sel(sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath model: comparator sign is 1 when r1 < r2
  assign sign = (r1_m < r2_m);

  // Operand registers, result memory and event counters
  always @(posedge clk) begin
    if (ld_r1) r1_m <= mem_a[addr_a];
    if (ld_r2) r2_m <= mem_a[addr_a];
    if (fill_b) begin
      for (int i = 0; i < 4; i++) mem_b[i] <= fill_val;
    end else if (we_b) begin
      mem_b[addr_b] <= sel ? (r1_m - r2_m) : (r1_m + r2_m);
    end
    if (we_b) begin
      wlog[wb_cnt % 64] = addr_b;
      wb_cnt = wb_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("we_a_zero", {31'd0, we_a}, 32'd0);
      check("ld_exclusive", {31'd0, ld_r1 & ld_r2}, 32'd0);
      if (we_b) check("sel_in_wr", {31'd0, sel}, {31'd0, (r1_m < r2_m)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    fill_val = v;
    fill_b   = 1'b1;
    step();
    fill_b   = 1'b0;
  endtask

  // Accept a start, then run ncyc cycles; optional extra start pulses
  task automatic run(input int p1, input int p2, input int ncyc,
                     output int dcyc, output int dcnt);
    start = 1'b1;
    step();
    start = 1'b0;
    dcyc  = 0;
    dcnt  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      start = (c == p1) || (c == p2);
      if (done) begin
        dcnt++;
        if (dcyc == 0) dcyc = c;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic check_b(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    check({tag, "_b0"}, {24'd0, mem_b[0]}, {24'd0, b0});
    check({tag, "_b1"}, {24'd0, mem_b[1]}, {24'd0, b1});
    check({tag, "_b2"}, {24'd0, mem_b[2]}, {24'd0, b2});
    check({tag, "_b3"}, {24'd0, mem_b[3]}, {24'd0, b3});
  endtask

  initial begin
    int dcyc, dcnt, w0, d0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; fill_b = 1'b0; fill_val = 8'd0;
    r1_m = 8'd0; r2_m = 8'd0;
    mem_a[0] = 8'd10; mem_a[1] = 8'd3; mem_a[2] = 8'd2; mem_a[3] = 8'd7;
    mem_a[4] = 8'd5;  mem_a[5] = 8'd5; mem_a[6] = 8'd0; mem_a[7] = 8'd255;
    step();
    step();
    // Reset state: every output zero
    check("rst_outs", {19'd0, addr_a, addr_b, we_a, we_b, ld_r1, ld_r2, sel, busy, done}, 32'd0);
    reset = 1'b1;
    fill(8'd0);

    // 1: full run
    w0 = wb_cnt;
    run(0, 0, 22, dcyc, dcnt);
    check("s1_done_cyc", dcyc, 17);
    check("s1_done_cnt", dcnt, 1);
    check("s1_wb_cnt", wb_cnt - w0, 4);
    for (int k = 0; k < 4; k++) check("s1_waddr", {30'd0, wlog[(w0 + k) % 64]}, k);
    check_b("s1", 8'd13, 8'd251, 8'd10, 8'd1);

    // 2: start pulses while busy are ignored
    fill(8'd0);
    w0 = wb_cnt;
    run(3, 9, 22, dcyc, dcnt);
    check("s2_done_cyc", dcyc, 17);
    check("s2_done_cnt", dcnt, 1);
    check("s2_wb_cnt", wb_cnt - w0, 4);
    check("s2_idle", {31'd0, busy}, 32'd0);
    check_b("s2", 8'd13, 8'd251, 8'd10, 8'd1);

    // 3: reset during WR of j=1
    fill(8'hEE);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("s3_in_wr", {30'd0, addr_b}, 1);
    reset = 1'b0;
    #1;
    check("s3_web_gated", {31'd0, we_b}, 32'd0);
    step();
    check("s3_outs", {19'd0, addr_a, addr_b, we_a, we_b, ld_r1, ld_r2, sel, busy, done}, 32'd0);
    reset = 1'b1;
    check("s3_b1_kept", {24'd0, mem_b[1]}, 32'hEE);
    run(0, 0, 20, dcyc, dcnt);
    check("s3_rerun_done", dcyc, 17);
    check_b("s3", 8'd13, 8'd251, 8'd10, 8'd1);

    // 4: abort in RD1 of j=2
    fill(8'hAA);
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("s4_in_rd1", {28'd0, ld_r2, addr_a}, {28'd0, 1'b1, 3'd5});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s4_idle", {31'd0, busy}, 32'd0);
    repeat (20) step();
    check("s4_no_done", done_cnt - d0, 0);
    check_b("s4", 8'd13, 8'd251, 8'hAA, 8'hAA);

    // 5: start held high, back-to-back runs
    start = 1'b1;
    step();
    for (int c = 1; c <= 36; c++) begin
      if (c == 17) check("s5_done1", {31'd0, done}, 32'd1);
      if (c == 18) check("s5_idle_gap", {31'd0, busy}, 32'd0);
      if (c == 19) check("s5_rd0", {28'd0, ld_r1, addr_a}, {28'd0, 1'b1, 3'd0});
      if (c == 35) check("s5_done2", {31'd0, done}, 32'd1);
      if (c == 36) start = 1'b0;
      step();
    end
    check("s5_final_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
